enc8to3_seq: RTL

//   Sequential 8-to-3 encoder: counterpart of the 3-to-8 decoders. Accepts an N-bit request vector.

---
 rtl/enc8to3_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/enc8to3_seq.sv
// Sequential N-to-log2(N) encoder with a single-entry request buffer.
// It accepts one request vector at a time and emits the binary index of each
// set bit, one index per out_valid/out_ready handshake. PRIO_HIGH selects the
// order: 0 emits the lowest index first, 1 emits the highest index first.
// A new vector is accepted only after the previous one has fully drained.
module enc8to3_seq #(
   parameter int unsigned IN_W      = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned PRIO_HIGH = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out,
   output logic             out_last,
   output logic             zero_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IN_W-1:0]   pending_q, pending_d;
   logic              zero_err_q, zero_err_d;

   logic [IDX_W-1:0]  sel_idx;
   logic              sel_found;
   logic              single_bit;
   logic [IN_W-1:0]   clear_mask;
   logic              accept;
   logic              xfer;

   // Priority-select the next pending index in the configured direction.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int unsigned i = 0; i < IN_W; i++) begin
         int unsigned j;
         j = (PRIO_HIGH != 0) ? (IN_W - 1 - i) : i;
         if (!sel_found && pending_q[j]) begin
            sel_idx   = IDX_W'(j);
            sel_found = 1'b1;
         end
      end
   end

   // Output side: a registered-only function of state and pending bits.
   always_comb begin
      single_bit = (pending_q != '0) &&
                   ((pending_q & (pending_q - IN_W'(1))) == '0);
      out_valid  = (state_q == DRAIN);
      out        = out_valid ? sel_idx : '0;
      out_last   = out_valid & single_bit;
      zero_err   = zero_err_q;
      clear_mask = {{(IN_W-1){1'b0}}, 1'b1} << sel_idx;
   end

   // Input side: ready only while idle, enabled, and out of reset.
   always_comb begin
      in_ready = (state_q == IDLE) & en & rst_n;
      accept   = in_valid & in_ready;
      xfer     = out_valid & out_ready;
   end

   // Next-state: load on accept, clear one bit per transfer, flag zero vectors.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in != '0) begin
                  pending_d = in;
                  state_d   = DRAIN;
               end else begin
                  zero_err_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (xfer) begin
               pending_d = pending_q & ~clear_mask;
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         zero_err_q <= zero_err_d;
      end
   end

endmodule
